// File: rtl/demux_pkg.sv
// Shared types for the 1:N stream demux: slot state encoding and the select decoder.
// Pure definitions; no clocked logic.
package demux_pkg;

  localparam int MAX_N     = 16;
  localparam int MAX_SEL_W = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [MAX_N-1:0] mask;
    logic             oor;
  } sel_dec_t;

  // One-hot decode limited to the first n channels; selects at or beyond n raise oor with an empty mask.
  function automatic sel_dec_t decode_sel(input logic [MAX_SEL_W-1:0] sel, input int n);
    sel_dec_t r;
    r.mask = '0;
    r.oor  = (int'(sel) >= n);
    for (int i = 0; i < MAX_N; i++) begin
      if ((i < n) && (int'(sel) == i)) r.mask[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single channel; load-to-valid latency 1 cycle.
// Holds data while out_ready is low; free also reports a same-cycle drain so the slot can reload back-to-back.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             free
);

  slot_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      data_out <= '0;
    end else begin
      if (load) data_out <= data_in;
      case (state)
        SLOT_EMPTY: if (load) state <= SLOT_FULL;
        SLOT_FULL:  if (out_ready && !load) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);
  assign free  = ~valid | out_ready;

endmodule

// File: rtl/demux_1ton_stream.sv
// Registered 1:N valid/ready demux with broadcast, out-of-range drop and transfer counter; latency 1 cycle.
// in_ready follows the targeted slot (or all slots for broadcast); out-of-range selects are always accepted.
module demux_1ton_stream
  import demux_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  N        = 4,
  parameter bit  BCAST_EN = 1'b1,
  parameter int  CNT_W    = 16,
  localparam int SEL_W    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic               bcast,
  input  logic [WIDTH-1:0]   inp,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] dout,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               err,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic             bcast_eff;
  logic             uni_ready;
  logic             accept;
  sel_dec_t         dec;
  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic [MAX_N-1:0] free_ext;

  assign bcast_eff = BCAST_EN & bcast;
  assign dec       = decode_sel(MAX_SEL_W'(sel), N);
  assign free_ext  = MAX_N'(free);

  // Broadcast is all-or-nothing so every consumer sees the same transfer sequence.
  assign uni_ready = dec.oor | (|(dec.mask & free_ext));
  assign in_ready  = ~rst & (bcast_eff ? (&free) : uni_ready);
  assign accept    = in_valid & in_ready;

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign load[k] = accept & (bcast_eff | dec.mask[k]);

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (inp),
      .out_ready(out_ready[k]),
      .valid    (out_valid[k]),
      .data_out (dout[k*WIDTH +: WIDTH]),
      .free     (free[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      err <= accept & ~bcast_eff & dec.oor;
      if (accept) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule
